// File: rtl/rtio_fifo_pkg.sv
// ---------------------------------------------------------------------------
// rtio_fifo_pkg
// Shared definitions for the RTIO asynchronous event FIFO controllers.
//   FIFO_ADDR_WIDTH : default RAM address width
//   ptr_width_f     : pointer width (one extra wrap bit) from an address width
//   depth_f         : FIFO depth from an address width
//   gray2bin        : gray-to-binary decode, used by write and read sides
//   arb_state_e     : write-arbiter state encoding
// ---------------------------------------------------------------------------
package rtio_fifo_pkg;

    localparam int FIFO_ADDR_WIDTH = 4;

    function automatic int ptr_width_f(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic int depth_f(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Each binary bit is the XOR of the gray bit at that position and every
    // bit above it; narrower pointers are zero-extended by the caller.
    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin = gray;
        for (int i = 1; i < 32; i++) begin
            bin = bin ^ (gray >> i);
        end
        return bin;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_BLOCKED = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rtio_fifo_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// rtio_fifo_write_arbiter_if
// Producer-facing request bus plus the FIFO RAM write port and status.
//   enable, req_valid, req_data, rd_ptr_gray_synced : into the arbiter
//   req_ready, fifo_we/waddr/wdata, fifo_level, fifo_full, ptr_error : out
// Modport slave is the arbiter; master is the producer/RAM/environment side.
// ---------------------------------------------------------------------------
interface rtio_fifo_write_arbiter_if
    import rtio_fifo_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
);
    localparam int PTR_WIDTH = ptr_width_f(ADDR_WIDTH);

    logic                        enable;
    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ*DATA_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]            req_ready;
    logic [PTR_WIDTH-1:0]        rd_ptr_gray_synced;
    logic                        fifo_we;
    logic [ADDR_WIDTH-1:0]       fifo_waddr;
    logic [DATA_WIDTH-1:0]       fifo_wdata;
    logic [PTR_WIDTH-1:0]        fifo_level;
    logic                        fifo_full;
    logic                        ptr_error;

    modport slave (
        input  enable, req_valid, req_data, rd_ptr_gray_synced,
        output req_ready, fifo_we, fifo_waddr, fifo_wdata,
               fifo_level, fifo_full, ptr_error
    );

    modport master (
        output enable, req_valid, req_data, rd_ptr_gray_synced,
        input  req_ready, fifo_we, fifo_waddr, fifo_wdata,
               fifo_level, fifo_full, ptr_error
    );

endinterface

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Rotating-priority arbiter: searches i_req starting at i_base, wrapping,
// and grants the first set bit.
//   i_req   : request vector
//   i_base  : highest-priority index this cycle
//   o_grant : one-hot-or-zero grant
//   o_idx   : index of the granted request (0 when none)
//   o_any   : at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_base,
    output logic [N_REQ-1:0] o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // Walk the requests in priority order; only the first hit is granted.
    always_comb begin
        int   w_pos;
        logic w_hit;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_pos   = 0;
        w_hit   = 1'b0;
        for (int off = 0; off < N_REQ; off++) begin
            w_pos          = (int'(i_base) + off) % N_REQ;
            w_hit          = i_req[w_pos] & ~o_any;
            o_grant[w_pos] = w_hit;
            o_idx          = w_hit ? IDX_W'(w_pos) : o_idx;
            o_any          = o_any | w_hit;
        end
    end

endmodule

// File: rtl/rtio_fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// rtio_fifo_write_arbiter
// Write-side controller of the RTIO async event FIFO. Round-robin shares the
// single RAM write port between N_REQ producers, owns the binary write
// pointer and derives level/full from the already-synchronized read pointer.
//   clk   : write-domain clock
//   reset : asynchronous active-high reset
//   bus   : request bus, RAM write port and status (slave modport)
// ---------------------------------------------------------------------------
module rtio_fifo_write_arbiter
    import rtio_fifo_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    rtio_fifo_write_arbiter_if.slave      bus
);

    localparam int PTR_WIDTH = ptr_width_f(ADDR_WIDTH);
    localparam int DEPTH     = depth_f(ADDR_WIDTH);
    localparam int IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PTR_WIDTH-1:0] DEPTH_P = PTR_WIDTH'(DEPTH);

    arb_state_e            r_state;
    arb_state_e            w_state_nxt;
    logic [PTR_WIDTH-1:0]  r_wr_ptr;
    logic [IDX_W-1:0]      r_rr_ptr;
    logic                  r_ptr_error;
    logic                  r_fifo_we;
    logic [ADDR_WIDTH-1:0] r_fifo_waddr;
    logic [DATA_WIDTH-1:0] r_fifo_wdata;
    logic [PTR_WIDTH-1:0]  r_fifo_level;
    logic                  r_fifo_full;

    logic [PTR_WIDTH-1:0]  w_rd_bin;
    logic [PTR_WIDTH-1:0]  w_level;
    logic [N_REQ-1:0]      w_grant;
    logic [IDX_W-1:0]      w_win_idx;
    logic                  w_any;
    logic [N_REQ-1:0]      w_ready;
    logic                  w_xfer;

    // Modulo subtraction keeps level continuous across the pointer wrap.
    assign w_rd_bin = PTR_WIDTH'(gray2bin(32'(bus.rd_ptr_gray_synced)));
    assign w_level  = r_wr_ptr - w_rd_bin;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
        .i_req   (bus.req_valid),
        .i_base  (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_win_idx),
        .o_any   (w_any)
    );

    // Next-state and ready gating. The decision uses the live pointers, not
    // the registered full flag, so a read-pointer change frees a slot in the
    // same cycle. Level beyond DEPTH is treated like full until ptr_error
    // latches on the next edge.
    always_comb begin
        w_state_nxt = ST_IDLE;
        case (r_state)
            ST_IDLE, ST_GRANT, ST_BLOCKED: begin
                if (reset || !bus.enable || !w_any || r_ptr_error) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_level >= DEPTH_P) begin
                    w_state_nxt = ST_BLOCKED;
                end else begin
                    w_state_nxt = ST_GRANT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_ready = (w_state_nxt == ST_GRANT) ? w_grant : '0;
        w_xfer  = |(bus.req_valid & w_ready);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Write pointer, rotation base and the registered RAM write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rr_ptr     <= '0;
            r_fifo_we    <= 1'b0;
            r_fifo_waddr <= '0;
            r_fifo_wdata <= '0;
        end else if (w_xfer) begin
            r_wr_ptr     <= r_wr_ptr + PTR_WIDTH'(1);
            r_rr_ptr     <= (w_win_idx == IDX_W'(N_REQ - 1)) ? '0 : w_win_idx + IDX_W'(1);
            r_fifo_we    <= 1'b1;
            r_fifo_waddr <= r_wr_ptr[ADDR_WIDTH-1:0];
            r_fifo_wdata <= bus.req_data[int'(w_win_idx)*DATA_WIDTH +: DATA_WIDTH];
        end else begin
            r_fifo_we    <= 1'b0;
        end
    end

    // Registered status; ptr_error is sticky until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fifo_level <= '0;
            r_fifo_full  <= 1'b0;
            r_ptr_error  <= 1'b0;
        end else begin
            r_fifo_level <= w_level;
            r_fifo_full  <= (w_level == DEPTH_P);
            r_ptr_error  <= r_ptr_error | (w_level > DEPTH_P);
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.fifo_we    = r_fifo_we;
    assign bus.fifo_waddr = r_fifo_waddr;
    assign bus.fifo_wdata = r_fifo_wdata;
    assign bus.fifo_level = r_fifo_level;
    assign bus.fifo_full  = r_fifo_full;
    assign bus.ptr_error  = r_ptr_error;

endmodule

// File: tb/tb_rtio_fifo_write_arbiter.sv
module tb_rtio_fifo_write_arbiter;

    localparam int N     = 4;
    localparam int DW    = 64;
    localparam int AW    = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    rtio_fifo_write_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    rtio_fifo_write_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Scoreboard and reference state
    wr_t         sb[$];
    logic [4:0]  m_wr;
    int          m_rr;
    logic [4:0]  m_lvl_prev;
    logic        m_err;
    logic [N-1:0] acc_mask;
    int          xfer_total;
    int          grant_log[$];

    logic [DW-1:0] word [N];
    bit keep_valid;
    bit follow;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] g2b(input logic [4:0] g);
        logic [4:0] b;
        b[4] = g[4];
        for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic logic [4:0] b2g(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    // Reference model and scoreboard, evaluated mid-cycle
    always @(negedge clk) begin : monitor
        logic [4:0]   lvl;
        logic [N-1:0] exp_rdy;
        int           win;
        int           c;
        wr_t          e;
        if (reset) begin
            sb.delete();
            m_wr       = 5'd0;
            m_rr       = 0;
            m_lvl_prev = 5'd0;
            m_err      = 1'b0;
            acc_mask   = '0;
            xfer_total = 0;
        end else begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("we", 64'(bus.fifo_we), 64'(1));
                chk("waddr", 64'(bus.fifo_waddr), 64'(e.addr));
                chk("wdata", bus.fifo_wdata, e.data);
            end else begin
                chk("we_idle", 64'(bus.fifo_we), 64'(0));
            end
            chk("level", 64'(bus.fifo_level), 64'(m_lvl_prev));
            chk("full", 64'(bus.fifo_full), 64'(m_lvl_prev == 5'd16));
            chk("ptr_error", 64'(bus.ptr_error), 64'(m_err));

            lvl     = m_wr - g2b(bus.rd_ptr_gray_synced);
            exp_rdy = '0;
            win     = -1;
            if (bus.enable && !m_err && lvl < 5'd16) begin
                for (int k = 0; k < N; k++) begin
                    c = (m_rr + k) % N;
                    if (win < 0 && bus.req_valid[c]) win = c;
                end
            end
            if (win >= 0) exp_rdy[win] = 1'b1;
            chk("ready", 64'(bus.req_ready), 64'(exp_rdy));

            acc_mask = bus.req_valid & bus.req_ready;
            for (int k = 0; k < N; k++) begin
                if (acc_mask[k]) begin
                    grant_log.push_back(k);
                    xfer_total++;
                end
            end
            if (win >= 0) begin
                e.addr = m_wr[AW-1:0];
                e.data = bus.req_data[win*DW +: DW];
                sb.push_back(e);
                m_wr = m_wr + 5'd1;
                m_rr = (win + 1) % N;
            end
            m_err      = m_err | (lvl > 5'd16);
            m_lvl_prev = lvl;
        end
    end

    task automatic pack_data();
        for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = word[i];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc_mask[i]) begin
                word[i] = {$urandom, $urandom};
                if (!keep_valid) bus.req_valid[i] = 1'b0;
            end
        end
        pack_data();
        if (follow) bus.rd_ptr_gray_synced = b2g(xfer_total >= 2 ? 5'(xfer_total - 2) : 5'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.rd_ptr_gray_synced = 5'd0;
        grant_log.delete();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int base;
        int cyc;
        bus.enable             = 1'b0;
        bus.req_valid          = '0;
        bus.rd_ptr_gray_synced = 5'd0;
        keep_valid             = 1'b1;
        follow                 = 1'b0;
        for (int i = 0; i < N; i++) word[i] = {$urandom, $urandom};
        pack_data();

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(bus.req_ready), 64'(0));
        chk("rst_we", 64'(bus.fifo_we), 64'(0));
        chk("rst_waddr", 64'(bus.fifo_waddr), 64'(0));
        chk("rst_wdata", bus.fifo_wdata, 64'(0));
        chk("rst_level", 64'(bus.fifo_level), 64'(0));
        chk("rst_full", 64'(bus.fifo_full), 64'(0));
        chk("rst_ptr_error", 64'(bus.ptr_error), 64'(0));
        reset = 1'b0;

        // All four requesting, reader parked at 0: fill to DEPTH
        bus.enable    = 1'b1;
        bus.req_valid = 4'b1111;
        repeat (20) step();
        chk("fill_count", 64'(xfer_total), 64'(16));
        chk("fill_full", 64'(bus.fifo_full), 64'(1));
        chk("fill_ready", 64'(bus.req_ready), 64'(0));

        // One slot freed: ready returns immediately, exactly one more write
        base = xfer_total;
        bus.rd_ptr_gray_synced = 5'b00001;
        #1;
        chk("free_ready", 64'(|bus.req_ready), 64'(1));
        repeat (4) step();
        chk("free_one_write", 64'(xfer_total - base), 64'(1));
        chk("free_full_again", 64'(bus.fifo_full), 64'(1));

        // Reader trailing by two over the pointer wrap
        do_reset();
        follow        = 1'b1;
        bus.enable    = 1'b1;
        bus.req_valid = 4'b1111;
        cyc = 0;
        while (cyc < 100 && xfer_total < 40) begin
            step();
            cyc++;
        end
        chk("wrap_reached", 64'(xfer_total >= 40), 64'(1));
        chk("wrap_level", 64'(bus.fifo_level), 64'(2));
        chk("wrap_no_full", 64'(bus.fifo_full), 64'(0));
        follow = 1'b0;

        // Rotation: 2 alone, then 1 and 3 join -> 3 then 1
        do_reset();
        keep_valid    = 1'b0;
        bus.enable    = 1'b1;
        bus.req_valid = 4'b0100;
        step();
        bus.req_valid = bus.req_valid | 4'b1010;
        repeat (3) step();
        chk("rot_count", 64'(grant_log.size()), 64'(3));
        chk("rot_first", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'(2));
        chk("rot_second", 64'(grant_log.size() > 1 ? grant_log[1] : -1), 64'(3));
        chk("rot_third", 64'(grant_log.size() > 2 ? grant_log[2] : -1), 64'(1));

        // Corrupted read pointer: level 20 sets sticky ptr_error
        do_reset();
        keep_valid    = 1'b1;
        bus.enable    = 1'b1;
        bus.req_valid = 4'b0001;
        repeat (4) step();
        bus.enable = 1'b0;
        bus.rd_ptr_gray_synced = b2g(5'(xfer_total - 20));
        bus.enable = 1'b1;
        repeat (2) step();
        chk("err_set", 64'(bus.ptr_error), 64'(1));
        chk("err_ready", 64'(bus.req_ready), 64'(0));
        bus.rd_ptr_gray_synced = b2g(5'(xfer_total));
        repeat (2) step();
        chk("err_sticky", 64'(bus.ptr_error), 64'(1));
        chk("err_sticky_ready", 64'(bus.req_ready), 64'(0));
        do_reset();
        chk("err_cleared", 64'(bus.ptr_error), 64'(0));

        // Reset right after a transfer drops fifo_we at once
        bus.enable    = 1'b1;
        bus.req_valid = 4'b0001;
        step();
        chk("pre_rst_we", 64'(bus.fifo_we), 64'(1));
        reset = 1'b1;
        #1;
        chk("async_we", 64'(bus.fifo_we), 64'(0));
        chk("async_waddr", 64'(bus.fifo_waddr), 64'(0));
        chk("async_wdata", bus.fifo_wdata, 64'(0));
        chk("async_level", 64'(bus.fifo_level), 64'(0));
        chk("async_ready", 64'(bus.req_ready), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        chk("post_rst_we", 64'(bus.fifo_we), 64'(1));
        chk("post_rst_addr", 64'(bus.fifo_waddr), 64'(0));
        repeat (3) step();

        bus.enable    = 1'b0;
        bus.req_valid = '0;
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
